// File: rtl/swipt_pwm_pkg.sv
// Shared definitions for the SWIPT bridge PWM path: FSM states, period width and
// default timing parameters.
package swipt_pwm_pkg;

   localparam int unsigned PERIOD_W       = 32;
   localparam int unsigned DEF_DEADTIME   = 10;
   localparam int unsigned DEF_MIN_PERIOD = 100;
   localparam int unsigned DEF_MAX_PERIOD = 100000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DT_LH = 3'd1,
      HIGH  = 3'd2,
      DT_HL = 3'd3,
      LOW   = 3'd4,
      STOP  = 3'd5
   } pwm_state_e;

endpackage

// File: rtl/pwm_period_clamp.sv
// Combinational period limiter with a flag telling whether the request was clipped.
module pwm_period_clamp
   import swipt_pwm_pkg::*;
#(
   parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD
) (
   input  logic [PERIOD_W-1:0] period,
   output logic [PERIOD_W-1:0] period_clamped,
   output logic                clamped
);

   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

   // Limit the requested period to the accepted window
   always_comb begin
      period_clamped = period;
      clamped        = 1'b0;
      if (period < MIN_P) begin
         period_clamped = MIN_P;
         clamped        = 1'b1;
      end else if (period > MAX_P) begin
         period_clamped = MAX_P;
         clamped        = 1'b1;
      end else begin
         period_clamped = period;
         clamped        = 1'b0;
      end
   end

endmodule

// File: rtl/bridge_pwm_gen.sv
// Half-bridge gate driver: DT_LH/HIGH/DT_HL/LOW cycle over a latched, clamped period.
// Defining PWM_CYCLE_COUNT_EN adds o_cycle_count, a saturating count of cycle strobes.
module bridge_pwm_gen
   import swipt_pwm_pkg::*;
#(
   parameter int unsigned DEADTIME   = DEF_DEADTIME,
   parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic                i_enable,
   output logic                o_gate_hi,
   output logic                o_gate_lo,
   output logic [PERIOD_W-1:0] o_period_active,
   output logic                o_cycle_strobe,
   output logic                o_clamped
`ifdef PWM_CYCLE_COUNT_EN
   ,
   output logic [PERIOD_W-1:0] o_cycle_count
`endif
);

   localparam logic [PERIOD_W-1:0] DT_LEN  = PERIOD_W'(DEADTIME);
   localparam logic [PERIOD_W-1:0] DT_LAST = DT_LEN - 32'd1;

   pwm_state_e          state_r;
   logic [PERIOD_W-1:0] cnt_r;
   logic [PERIOD_W-1:0] clamp_period_s;
   logic                clamp_flag_s;
   logic [PERIOD_W-1:0] half_s;
   logic [PERIOD_W-1:0] h_last_s;
   logic [PERIOD_W-1:0] l_last_s;

   pwm_period_clamp #(
      .MIN_PERIOD (MIN_PERIOD),
      .MAX_PERIOD (MAX_PERIOD)
   ) u_clamp (
      .period         (i_period),
      .period_clamped (clamp_period_s),
      .clamped        (clamp_flag_s)
   );

   // Odd periods leave the extra clock in the LOW phase
   assign half_s   = o_period_active >> 1;
   assign h_last_s = half_s - DT_LEN - 32'd1;
   assign l_last_s = o_period_active - half_s - DT_LEN - 32'd1;

   // Phase sequencing, period latch and registered gate drive
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_r         <= IDLE;
         cnt_r           <= 32'd0;
         o_gate_hi       <= 1'b0;
         o_gate_lo       <= 1'b0;
         o_period_active <= 32'd0;
         o_cycle_strobe  <= 1'b0;
         o_clamped       <= 1'b0;
      end else begin
         o_cycle_strobe <= 1'b0;
         case (state_r)
            IDLE: begin
               if (i_enable) begin
                  state_r         <= DT_LH;
                  cnt_r           <= DT_LAST;
                  o_period_active <= clamp_period_s;
                  o_clamped       <= clamp_flag_s;
                  o_cycle_strobe  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            DT_LH, HIGH, DT_HL, LOW: begin
               if (!i_enable) begin
                  state_r   <= STOP;
                  cnt_r     <= DT_LAST;
                  o_gate_hi <= 1'b0;
                  o_gate_lo <= 1'b0;
               end else if (cnt_r != 32'd0) begin
                  cnt_r <= cnt_r - 32'd1;
               end else begin
                  case (state_r)
                     DT_LH: begin
                        state_r   <= HIGH;
                        cnt_r     <= h_last_s;
                        o_gate_hi <= 1'b1;
                     end
                     HIGH: begin
                        state_r   <= DT_HL;
                        cnt_r     <= DT_LAST;
                        o_gate_hi <= 1'b0;
                     end
                     DT_HL: begin
                        state_r   <= LOW;
                        cnt_r     <= l_last_s;
                        o_gate_lo <= 1'b1;
                     end
                     LOW: begin
                        state_r         <= DT_LH;
                        cnt_r           <= DT_LAST;
                        o_gate_lo       <= 1'b0;
                        o_period_active <= clamp_period_s;
                        o_clamped       <= clamp_flag_s;
                        o_cycle_strobe  <= 1'b1;
                     end
                     default: begin
                        state_r   <= IDLE;
                        o_gate_hi <= 1'b0;
                        o_gate_lo <= 1'b0;
                     end
                  endcase
               end
            end
            STOP: begin
               if (cnt_r == 32'd0) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r - 32'd1;
               end
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= 32'd0;
               o_gate_hi <= 1'b0;
               o_gate_lo <= 1'b0;
            end
         endcase
      end
   end

`ifdef PWM_CYCLE_COUNT_EN
   // Saturating count of cycle-start strobes
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         o_cycle_count <= 32'd0;
      end else if (o_cycle_strobe && (o_cycle_count != 32'hFFFF_FFFF)) begin
         o_cycle_count <= o_cycle_count + 32'd1;
      end else begin
         o_cycle_count <= o_cycle_count;
      end
   end
`endif

endmodule

// File: tb/tb_bridge_pwm_gen.sv
// Self-checking bench for bridge_pwm_gen: vector table, directed corner sequences
// and randomized run against a position-in-cycle reference model.
module tb_bridge_pwm_gen;

   localparam int D    = 10;
   localparam int MINP = 100;
   localparam int MAXP = 100000;
   localparam int LIM  = 4000;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        en = 1'b0;
   logic [31:0] per = 32'd0;
   logic        gate_hi, gate_lo, strobe, clamped;
   logic [31:0] pa;
`ifdef PWM_CYCLE_COUNT_EN
   logic [31:0] cycle_count;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 running, 2 stop
   int          m_mode = 0;
   int unsigned m_pos = 0, m_p = 0, m_left = 0;
   logic        m_strobe = 1'b0, m_cl = 1'b0;
   logic [31:0] m_count = 32'd0;

   typedef struct {
      logic [31:0] period;
      logic [31:0] exp_pa;
      logic        exp_cl;
      int          exp_hi;
      int          exp_lo;
      bit          measure;
   } vec_t;
   vec_t vecs[9];

   bridge_pwm_gen #(
      .DEADTIME   (D),
      .MIN_PERIOD (MINP),
      .MAX_PERIOD (MAXP)
   ) dut (
      .i_clk           (clk),
      .i_nrst          (nrst),
      .i_period        (per),
      .i_enable        (en),
      .o_gate_hi       (gate_hi),
      .o_gate_lo       (gate_lo),
      .o_period_active (pa),
      .o_cycle_strobe  (strobe),
      .o_clamped       (clamped)
`ifdef PWM_CYCLE_COUNT_EN
      ,
      .o_cycle_count   (cycle_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 50) $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_start();
      if (per < 32'(MINP)) begin
         m_p = MINP; m_cl = 1'b1;
      end else if (per > 32'(MAXP)) begin
         m_p = MAXP; m_cl = 1'b1;
      end else begin
         m_p = per; m_cl = 1'b0;
      end
      m_mode = 1; m_pos = 0; m_strobe = 1'b1;
   endtask

   task automatic model_edge();
      if (!nrst) begin
         m_mode = 0; m_pos = 0; m_p = 0; m_left = 0;
         m_strobe = 1'b0; m_cl = 1'b0; m_count = 32'd0;
      end else begin
         if (m_strobe && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
         m_strobe = 1'b0;
         case (m_mode)
            0: if (en) model_start();
            1: begin
               if (!en) begin
                  m_mode = 2; m_left = D;
               end else if (m_pos == m_p - 1) begin
                  model_start();
               end else begin
                  m_pos++;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         endcase
      end
   endtask

   function automatic logic exp_hi();
      int unsigned h;
      h = m_p / 2 - D;
      return (m_mode == 1) && (m_pos >= D) && (m_pos < D + h);
   endfunction

   function automatic logic exp_lo();
      int unsigned l;
      l = m_p - m_p / 2 - D;
      return (m_mode == 1) && (m_pos >= m_p - l);
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("gate_hi", 32'(gate_hi), 32'(exp_hi()));
      chk("gate_lo", 32'(gate_lo), 32'(exp_lo()));
      chk("overlap", 32'(gate_hi & gate_lo), 32'd0);
      chk("strobe", 32'(strobe), 32'(m_strobe));
      chk("period_active", pa, m_p);
      chk("clamped", 32'(clamped), 32'(m_cl));
`ifdef PWM_CYCLE_COUNT_EN
      chk("cycle_count", cycle_count, m_count);
`endif
   endtask

   task automatic run_len(input logic whi, input logic wlo, output int n);
      n = 0;
      while (gate_hi == whi && gate_lo == wlo && n < LIM) begin
         n++;
         step();
      end
   endtask

   task automatic to_strobe(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!strobe && n < 3 * LIM);
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      step();
      nrst = 1'b1;
   endtask

   initial begin
      int n, dt1, hi, dt2, lo;
      vecs[0] = '{32'd1900,   32'd1900,   1'b0, 940, 940, 1'b1};
      vecs[1] = '{32'd1901,   32'd1901,   1'b0, 940, 941, 1'b1};
      vecs[2] = '{32'd50,     32'd100,    1'b1, 40,  40,  1'b1};
      vecs[3] = '{32'd200000, 32'd100000, 1'b1, 0,   0,   1'b0};
      vecs[4] = '{32'd100,    32'd100,    1'b0, 40,  40,  1'b1};
      vecs[5] = '{32'd99,     32'd100,    1'b1, 40,  40,  1'b1};
      vecs[6] = '{32'd101,    32'd101,    1'b0, 40,  41,  1'b1};
      vecs[7] = '{32'd100000, 32'd100000, 1'b0, 0,   0,   1'b0};
      vecs[8] = '{32'd0,      32'd100,    1'b1, 40,  40,  1'b1};

      // reset state
      en = 1'b1; per = 32'd1900;
      do_reset();
      en = 1'b0;
      chk("rst_gate_hi", 32'(gate_hi), 32'd0);
      chk("rst_gate_lo", 32'(gate_lo), 32'd0);
      chk("rst_period", pa, 32'd0);
      chk("rst_strobe", 32'(strobe), 32'd0);
      chk("rst_clamped", 32'(clamped), 32'd0);
`ifdef PWM_CYCLE_COUNT_EN
      chk("rst_count", cycle_count, 32'd0);
`endif

      // vector table
      for (int i = 0; i < 9; i++) begin
         en = 1'b0; per = vecs[i].period;
         do_reset();
         step();
         en = 1'b1;
         step();
         chk("vec_strobe", 32'(strobe), 32'd1);
         chk("vec_period", pa, vecs[i].exp_pa);
         chk("vec_clamped", 32'(clamped), 32'(vecs[i].exp_cl));
         if (vecs[i].measure) begin
            run_len(1'b0, 1'b0, dt1);
            run_len(1'b1, 1'b0, hi);
            run_len(1'b0, 1'b0, dt2);
            run_len(1'b0, 1'b1, lo);
            chk("vec_dt_lh", dt1, D);
            chk("vec_hi_len", hi, vecs[i].exp_hi);
            chk("vec_dt_hl", dt2, D);
            chk("vec_lo_len", lo, vecs[i].exp_lo);
            chk("vec_next_strobe", 32'(strobe), 32'd1);
            to_strobe(n);
            chk("vec_repeat_len", n, vecs[i].exp_pa);
         end
      end

      // period change mid-HIGH applies at next cycle only
      en = 1'b0; per = 32'd1900;
      do_reset();
      en = 1'b1;
      step();
      for (int k = 0; k < 110; k++) step();
      chk("chg_in_high", 32'(gate_hi), 32'd1);
      per = 32'd2000;
      to_strobe(n);
      chk("chg_cur_len", 110 + n, 1900);
      chk("chg_new_period", pa, 32'd2000);
      to_strobe(n);
      chk("chg_next_len", n, 2000);

      // enable drop mid-HIGH, immediate re-request during STOP
      for (int k = 0; k < 50; k++) step();
      chk("drop_in_high", 32'(gate_hi), 32'd1);
      en = 1'b0;
      step();
      chk("drop_hi_off", 32'(gate_hi), 32'd0);
      chk("drop_lo_off", 32'(gate_lo), 32'd0);
      en = 1'b1;
      to_strobe(n);
      chk("drop_restart_gap", n, D + 1);
      run_len(1'b0, 1'b0, dt1);
      chk("drop_restart_dt", dt1, D);

      // reset mid-LOW
      per = 32'd200;
      to_strobe(n);
      for (int k = 0; k < 199; k++) step();
      to_strobe(n);
      for (int k = 0; k < 150; k++) step();
      chk("rstlow_in_low", 32'(gate_lo), 32'd1);
      nrst = 1'b0;
      step();
      chk("rstlow_hi", 32'(gate_hi), 32'd0);
      chk("rstlow_lo", 32'(gate_lo), 32'd0);
      chk("rstlow_period", pa, 32'd0);
      chk("rstlow_strobe", 32'(strobe), 32'd0);
      chk("rstlow_clamped", 32'(clamped), 32'd0);
      nrst = 1'b1;
      step();
      chk("rstlow_restart", 32'(strobe), 32'd1);
`ifdef PWM_CYCLE_COUNT_EN
      chk("rstlow_count0", cycle_count, 32'd0);
      step();
      chk("rstlow_count1", cycle_count, 32'd1);
      to_strobe(n);
      step();
      chk("rstlow_count2", cycle_count, 32'd2);
`endif

      // randomized run against the reference model
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(299, 0) == 0) en = ~en;
         if ($urandom_range(99, 0) == 0) per = $urandom_range(420, 40);
         if ($urandom_range(1999, 0) == 0) nrst = 1'b0;
         else nrst = 1'b1;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bridge_pwm_gen.md
BRIDGE_PWM_GEN -- requirements
Module: bridge_pwm_gen

Interface
REQ-001 The block SHALL have parameter DEADTIME, default 10: both-gates-low cycles at every gate transition.
REQ-002 The block SHALL have parameter MIN_PERIOD, default 100: smallest accepted period, in clocks.
REQ-003 The block SHALL have parameter MAX_PERIOD, default 100000: largest accepted period, in clocks.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port i_nrst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port i_period, input, 32 bits: requested bridge period in i_clk cycles, from the frequency tracker's o_freq.
REQ-007 The block SHALL have port i_enable, input, 1 bit: run request, from the tracker's o_enable.
REQ-008 The block SHALL have port o_gate_hi, output, 1 bit: high-side gate drive.
REQ-009 The block SHALL have port o_gate_lo, output, 1 bit: low-side gate drive.
REQ-010 The block SHALL have port o_period_active, output, 32 bits: the latched, clamped period in use.
REQ-011 The block SHALL have port o_cycle_strobe, output, 1 bit: one-clock pulse at each cycle start.
REQ-012 The block SHALL have port o_clamped, output, 1 bit: the last latched period was clamped.

Function
REQ-013 The FSM SHALL have states IDLE, DT_LH, HIGH, DT_HL, LOW and STOP.
REQ-014 In IDLE with i_enable=1, the FSM SHALL enter DT_LH on the next clock; in IDLE with i_enable=0, it SHALL stay in IDLE.
REQ-015 On each entry to DT_LH, the block SHALL latch P = clamp(i_period, MIN_PERIOD, MAX_PERIOD) into o_period_active, set o_clamped when clamping occurred (else clear it), and pulse o_cycle_strobe for one clock.
REQ-016 Phase lengths SHALL be: H = (P>>1) - DEADTIME and L = P - (P>>1) - DEADTIME; odd P gives the LOW phase the extra clock.
REQ-017 Each cycle SHALL run DT_LH for DEADTIME clocks, HIGH for H clocks, DT_HL for DEADTIME clocks, then LOW for L clocks, totalling exactly P clocks.
REQ-018 o_gate_hi SHALL be 1 only in HIGH, and o_gate_lo SHALL be 1 only in LOW; both SHALL never be 1 in the same clock.
REQ-019 At the end of LOW with i_enable=1, the FSM SHALL enter DT_LH, starting the next cycle with no gap.
REQ-020 A change of i_period mid-cycle SHALL take effect only at the next DT_LH entry.
REQ-021 i_enable=0 sampled in DT_LH, HIGH, DT_HL or LOW SHALL move the FSM to STOP on the next clock, with both gates 0 from that clock.
REQ-022 STOP SHALL last DEADTIME clocks, then go to IDLE, even if i_enable has returned to 1.
REQ-023 Phase counters SHALL be 32-bit unsigned and load (length-1) on phase entry, counting down to 0.
REQ-024 The block SHALL require MIN_PERIOD >= 2*DEADTIME+2, so that H>=1 and L>=1.

Reset
REQ-025 When i_nrst=0 at a clock edge, the block SHALL go to IDLE and drive o_gate_hi=0, o_gate_lo=0, o_period_active=0, o_cycle_strobe=0, o_clamped=0, and zero all counters.
REQ-026 A reset asserted mid-cycle SHALL drive both gates to 0 on that same edge, with no STOP dead time required.

Configuration
REQ-027 With macro PWM_CYCLE_COUNT_EN defined, the block SHALL add output o_cycle_count (32 bits) counting o_cycle_strobe pulses, saturating at 0xFFFFFFFF and reset to 0.
REQ-028 Without PWM_CYCLE_COUNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package swipt_pwm_pkg SHALL hold the state enum, the period width constant (32), and the default DEADTIME, MIN_PERIOD and MAX_PERIOD values.
REQ-030 The block SHALL contain one sub-module, pwm_period_clamp: combinational clamp plus clamped flag, shareable with other period consumers.

Verification
REQ-031 Bench SHALL check: reset, then i_enable=1, i_period=1900 -> strobe at DT_LH entry; 10 low, hi 940, 10 low, lo 940; repeat period 1900.
REQ-032 Bench SHALL check: i_period=1901 -> hi 940, lo 941; o_period_active=1901; o_clamped=0.
REQ-033 Bench SHALL check: i_period=50 -> o_period_active=100, o_clamped=1, hi 40, lo 40; i_period=200000 -> 100000, o_clamped=1.
REQ-034 Bench SHALL check: i_period changes 1900->2000 mid-HIGH -> current cycle stays 1900 clocks, next cycle is 2000.
REQ-035 Bench SHALL check: i_enable drops mid-HIGH -> gates 0 next clock, 10 clocks STOP, then IDLE; re-enable restarts with a dead time; gate overlap never occurs.
REQ-036 Bench SHALL check: i_nrst=0 mid-LOW -> all outputs 0 at that edge; with PWM_CYCLE_COUNT_EN, o_cycle_count=0 and increments once per strobe afterwards.
